// File: rtl/eca_column_streamer.sv
// Elementary cellular automaton row stepped once per cycle; the TAP column is
// packed into OUT_W-bit words and streamed out under valid/ready flow control.
module eca_column_streamer #(
  parameter int N     = 128,
  parameter int OUT_W = 32,
  parameter int CNT_W = 16,
  parameter int TAP   = N / 2,
  parameter int WRAP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [N-1:0]     seed,
  input  logic [7:0]       rule,
  input  logic [CNT_W-1:0] warmup,
  input  logic [CNT_W-1:0] words,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [N-1:0]     state_row
);

  localparam int BCNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  typedef enum logic [1:0] {IDLE, WARM, RUN, DRAIN} state_t;

  state_t            state;
  logic [7:0]        rule_q;
  logic [CNT_W-1:0]  warm_left;
  logic [CNT_W-1:0]  words_left;
  logic [BCNT_W-1:0] bcnt;
  logic [OUT_W-2:0]  acc;
  logic [N-1:0]      row;
  logic [N-1:0]      row_nxt;
  logic [N+1:0]      ext;
  logic [OUT_W-1:0]  word_nxt;
  logic              last_bit;
  logic              stall;
  logic              accept;

  // Row padded with its two out-of-range neighbours so every cell sees {left, centre, right}.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    row_nxt = '0;
    ext = {(WRAP != 0) ? row[0] : 1'b0, row, (WRAP != 0) ? row[N-1] : 1'b0};
    for (int i = 0; i < N; i++) begin
      row_nxt[i] = rule_q[ext[i +: 3]];
    end
  end

  // Earlier column bits sit in acc with the earliest at the LSB; the live tap bit completes the word.
  assign word_nxt  = {row[TAP], acc};
  assign last_bit  = (bcnt == BCNT_W'(OUT_W - 1));
  assign stall     = out_valid & ~out_ready & last_bit;
  assign accept    = out_valid & out_ready;
  assign busy      = (state != IDLE);
  assign state_row = row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rule_q     <= '0;
      warm_left  <= '0;
      words_left <= '0;
      bcnt       <= '0;
      acc        <= '0;
      row        <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              row        <= seed;
              rule_q     <= rule;
              warm_left  <= warmup;
              words_left <= words;
              bcnt       <= '0;
              if (words == '0) begin
                done <= 1'b1;
              end else if (warmup == '0) begin
                state <= RUN;
              end else begin
                state <= WARM;
              end
            end
          end
          WARM: begin
            row       <= row_nxt;
            warm_left <= warm_left - CNT_W'(1);
            if (warm_left == CNT_W'(1)) state <= RUN;
          end
          RUN: begin
            if (accept) out_valid <= 1'b0;
            if (!stall) begin
              row <= row_nxt;
              acc <= word_nxt[OUT_W-1:1];
              if (last_bit) begin
                out_data   <= word_nxt;
                out_valid  <= 1'b1;
                bcnt       <= '0;
                words_left <= words_left - CNT_W'(1);
                if (words_left == CNT_W'(1)) state <= DRAIN;
              end else begin
                bcnt <= bcnt + BCNT_W'(1);
              end
            end
          end
          DRAIN: begin
            if (accept) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eca_column_streamer.sv
// Bench for eca_column_streamer: a word-level CA model feeds a queue that a
// per-cycle compare process checks, plus hand-computed literal expectations.
module tb_eca_column_streamer;

  localparam logic [63:0] T1_SEED = 64'h0000_0001_0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start, abort, out_ready;
  logic [63:0] seed;
  logic [7:0]  rule;
  logic [15:0] warmup, words;
  logic        busy, done, out_valid;
  logic [7:0]  out_data;
  logic [63:0] state_row;

  logic        s_start, s_abort, s_ready;
  logic [7:0]  s_seed, s_rule;
  logic [15:0] s_warmup, s_words;
  logic        sw_busy, sw_done, sw_valid, sn_busy, sn_done, sn_valid;
  logic [7:0]  sw_data, sw_row, sn_data, sn_row;

  int n_checks = 0;
  int n_pass   = 0;
  int done_seen = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  eca_column_streamer #(.N(64), .OUT_W(8), .CNT_W(16), .TAP(32), .WRAP(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed), .rule(rule),
    .warmup(warmup), .words(words), .busy(busy), .done(done), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .state_row(state_row)
  );

  eca_column_streamer #(.N(8), .OUT_W(8), .CNT_W(16), .TAP(4), .WRAP(1)) dut_wrap (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .seed(s_seed), .rule(s_rule),
    .warmup(s_warmup), .words(s_words), .busy(sw_busy), .done(sw_done), .out_valid(sw_valid),
    .out_ready(s_ready), .out_data(sw_data), .state_row(sw_row)
  );

  eca_column_streamer #(.N(8), .OUT_W(8), .CNT_W(16), .TAP(4), .WRAP(0)) dut_nowrap (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .seed(s_seed), .rule(s_rule),
    .warmup(s_warmup), .words(s_words), .busy(sn_busy), .done(sn_done), .out_valid(sn_valid),
    .out_ready(s_ready), .out_data(sn_data), .state_row(sn_row)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else n_pass++;
  endtask

  // Cyclic elementary CA step on a 64-cell row, straight from the rule table.
  function automatic logic [63:0] step64(input logic [63:0] r, input logic [7:0] ru);
    logic [63:0] n;
    for (int i = 0; i < 64; i++) n[i] = ru[{r[(i + 1) % 64], r[i], r[(i + 63) % 64]}];
    return n;
  endfunction

  function automatic logic [63:0] row_after(input logic [63:0] s, input logic [7:0] ru, input int k);
    logic [63:0] r;
    r = s;
    for (int i = 0; i < k; i++) r = step64(r, ru);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [63:0] s, input logic [7:0] ru, input int wu, input int nw);
    logic [63:0] r;
    logic [7:0]  w;
    r = row_after(s, ru, wu);
    for (int k = 0; k < nw; k++) begin
      for (int b = 0; b < 8; b++) begin
        w[b] = r[32];
        r = step64(r, ru);
      end
      exp_q.push_back(w);
    end
    seed = s; rule = ru; warmup = 16'(wu); words = 16'(nw); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 200);
    check("valid_seen", out_valid, 1);
  endtask

  task automatic wait_word(output logic [7:0] w);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(out_valid && out_ready) && k < 200);
    w = (out_valid && out_ready) ? out_data : 8'hxx;
  endtask

  task automatic wait_done(input int d0, input string tag);
    for (int k = 0; k < 100 && done_seen == d0; k++) tick();
    repeat (3) tick();
    check({tag, "_done_once"}, 64'(done_seen - d0), 1);
  endtask

  task automatic run_t1(input string tag);
    int n, d0;
    logic [7:0] w;
    d0 = done_seen;
    out_ready = 1'b1;
    launch(T1_SEED, 8'h1E, 0, 2);
    check({tag, "_busy"}, busy, 1);
    wait_valid(n);
    check({tag, "_latency"}, n, 9);
    check({tag, "_word0"}, out_data, 8'h3B);
    wait_word(w);
    check({tag, "_word1"}, w, 8'hA3);
    wait_done(d0, tag);
    check({tag, "_row_final"}, state_row, row_after(T1_SEED, 8'h1E, 16));
    check({tag, "_idle"}, busy, 0);
  endtask

  // Every cycle a word is presented it must match the model's oldest pending word.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", out_valid, 0);
        end else begin
          check("out_data", out_data, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (done) begin
        done_seen++;
        check("done_after_last_word", 64'(exp_q.size()), 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    int n, d0;
    logic [7:0] w;
    start = 0; abort = 0; out_ready = 1; seed = '0; rule = '0; warmup = '0; words = '0;
    s_start = 0; s_abort = 0; s_ready = 1; s_seed = '0; s_rule = '0; s_warmup = '0; s_words = '0;

    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_row", state_row, 0);
    check("rst_small_row", sw_row, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Rule 30 centre column from a single live cell.
    run_t1("t1");

    // Rule 0xAA copies the right neighbour, so the row rotates left by one per step.
    s_seed = 8'h80; s_rule = 8'hAA; s_warmup = 16'd1; s_words = 16'd0; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    check("t2_done_w0_wrap", sw_done, 1);
    check("t2_done_w0_nowrap", sn_done, 1);
    check("t2_idle_w0", sw_busy, 0);
    tick();
    check("t2_done_pulse_ends", sw_done, 0);
    s_words = 16'd1; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    check("t2_busy", sw_busy, 1);
    tick();
    check("t2_row_wrap", sw_row, 8'h01);
    check("t2_row_nowrap", sn_row, 8'h00);
    for (int k = 0; k < 50 && !sw_valid; k++) @(negedge clk);
    check("t2_valid", sw_valid, 1);
    check("t2_word_wrap", sw_data, 8'h10);
    check("t2_word_nowrap", sn_data, 8'h00);
    repeat (3) tick();
    check("t2_idle", sw_busy, 0);

    // Identity rule with a live tap cell; a start with junk seed/rule mid-job must be ignored.
    d0 = done_seen;
    launch(T1_SEED, 8'hCC, 3, 3);
    wait_valid(n);
    check("t3_latency", n, 12);
    check("t3_word0", out_data, 8'hFF);
    seed = '0; rule = 8'h00; words = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_word(w);
    check("t3_word1", w, 8'hFF);
    wait_word(w);
    check("t3_word2", w, 8'hFF);
    wait_done(d0, "t3");

    // Backpressure on the first word freezes the row at the next word's last bit.
    out_ready = 1'b0;
    d0 = done_seen;
    launch(T1_SEED, 8'h1E, 0, 2);
    wait_valid(n);
    check("t4_latency", n, 9);
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      check("t4_hold_data", out_data, 8'h3B);
    end
    check("t4_row_frozen", state_row, row_after(T1_SEED, 8'h1E, 15));
    check("t4_valid_held", out_valid, 1);
    tick();
    out_ready = 1'b1;
    wait_word(w);
    check("t4_word0", w, 8'h3B);
    wait_word(w);
    check("t4_word1", w, 8'hA3);
    wait_done(d0, "t4");
    check("t4_row_final", state_row, row_after(T1_SEED, 8'h1E, 16));

    // Abort during warmup: two steps taken, the aborting edge takes none.
    d0 = done_seen;
    launch(T1_SEED, 8'h1E, 5, 2);
    tick();
    tick();
    check("t5_warm_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    check("t5_warm_abort_busy", busy, 0);
    check("t5_warm_abort_valid", out_valid, 0);
    check("t5_warm_row_held", state_row, row_after(T1_SEED, 8'h1E, 2));

    // Abort while the first word is presented: data and row hold, no done.
    launch(T1_SEED, 8'h1E, 0, 2);
    wait_valid(n);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    check("t5_run_abort_busy", busy, 0);
    check("t5_run_abort_valid", out_valid, 0);
    check("t5_run_data_held", out_data, 8'h3B);
    repeat (4) tick();
    check("t5_run_row_held", state_row, row_after(T1_SEED, 8'h1E, 8));
    check("t5_no_done", 64'(done_seen - d0), 0);
    run_t1("t5_restart");

    // Asynchronous reset between clock edges while a word is presented.
    d0 = done_seen;
    out_ready = 1'b1;
    launch(T1_SEED, 8'h1E, 0, 2);
    wait_valid(n);
    #1;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_valid", out_valid, 0);
    check("t6_data", out_data, 0);
    check("t6_row", state_row, 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("t6_idle", busy, 0);
    check("t6_no_done", 64'(done_seen - d0), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
